// File: rtl/matvec_pkg.sv
// Shared types and sizes for the matrix-vector sequencing controller.
// Holds the FSM state encoding and the MAC tag carried down the pipeline.
package matvec_pkg;

    localparam int K_DEF     = 8;
    localparam int PIPE_DEF  = 2;
    localparam int OUT_W_DEF = 28;

    localparam int AW_M = $clog2(K_DEF * K_DEF);
    localparam int AW_X = $clog2(K_DEF);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_M,
        LOAD_X,
        COMPUTE
    } state_t;

    typedef struct packed {
        logic first;
        logic last;
    } tag_t;

endpackage

// File: rtl/matvec_outbuf.sv
// Two-entry result FIFO in front of the output valid/ready port.
// Head is held steady until it is dequeued; push and pop may coincide.
module matvec_outbuf
    import matvec_pkg::*;
#(
    parameter int W = OUT_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wptr;
    logic         rptr;
    logic         pop_ok;

    assign valid  = (count != 2'd0);
    assign pop_ok = pop & valid;
    assign dout   = mem[rptr];

    // Ring storage with independent read and write pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= ~wptr;
            end
            if (pop_ok) begin
                rptr <= ~rptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/matvec_seq_ctrl.sv
// Sequencer for the K x K matrix-vector multiplier: load addressing,
// row-by-row MAC issue with a two-row credit limit, and result buffering.
module matvec_seq_ctrl
    import matvec_pkg::*;
#(
    parameter int K     = K_DEF,
    parameter int PIPE  = PIPE_DEF,
    parameter int OUT_W = OUT_W_DEF,
    localparam int AWM  = $clog2(K * K),
    localparam int AWX  = $clog2(K)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             input_valid,
    output logic             input_ready,
    input  logic             new_matrix,
    output logic             wr_en_m,
    output logic             wr_en_x,
    output logic [AWM-1:0]   wr_addr,
    output logic [AWM-1:0]   rd_addr_m,
    output logic [AWX-1:0]   rd_addr_x,
    output logic             mac_en,
    output logic             mac_clr,
    input  logic [OUT_W-1:0] acc_in,
    output logic             output_valid,
    input  logic             output_ready,
    output logic [OUT_W-1:0] output_data
);

    localparam logic [AWM-1:0] M_LAST  = AWM'(K * K - 1);
    localparam logic [AWM-1:0] XW_LAST = AWM'(K - 1);
    localparam logic [AWX-1:0] C_LAST  = AWX'(K - 1);

    state_t          state;
    logic [AWX-1:0]  r_cnt;
    logic [1:0]      outstanding;
    logic            in_hs;
    logic            issue;
    logic            row_start;
    logic            col_last;
    logic            row_last;
    logic            out_hs;
    logic [PIPE-1:0] pv;
    tag_t            pt [PIPE];
    logic            push_q;
    logic [1:0]      buf_cnt;

    assign input_ready = reset & (state != COMPUTE);
    assign in_hs       = input_valid & input_ready;

    assign wr_en_m = in_hs & ((state == LOAD_M) |
                              ((state == IDLE) & new_matrix));
    assign wr_en_x = in_hs & ((state == LOAD_X) |
                              ((state == IDLE) & ~new_matrix));

    assign col_last  = (rd_addr_x == C_LAST);
    assign row_last  = (r_cnt == C_LAST);
    assign issue     = (state == COMPUTE) &
                       ((rd_addr_x != '0) | (outstanding < 2'd2));
    assign row_start = issue & (rd_addr_x == '0);
    assign out_hs    = output_valid & output_ready;

    assign mac_en  = pv[PIPE-1];
    assign mac_clr = pv[PIPE-1] & pt[PIPE-1].first;

    // Main FSM: write addressing during loads, (r,c) issue during compute.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wr_addr   <= '0;
            rd_addr_m <= '0;
            rd_addr_x <= '0;
            r_cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_hs) begin
                        wr_addr <= AWM'(1);
                        state   <= new_matrix ? LOAD_M : LOAD_X;
                    end
                end
                LOAD_M: begin
                    if (in_hs) begin
                        if (wr_addr == M_LAST) begin
                            wr_addr <= '0;
                            state   <= LOAD_X;
                        end else begin
                            wr_addr <= wr_addr + 1'b1;
                        end
                    end
                end
                LOAD_X: begin
                    if (in_hs) begin
                        if (wr_addr == XW_LAST) begin
                            wr_addr <= '0;
                            state   <= COMPUTE;
                        end else begin
                            wr_addr <= wr_addr + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (issue) begin
                        if (col_last) begin
                            rd_addr_x <= '0;
                            if (row_last) begin
                                r_cnt     <= '0;
                                rd_addr_m <= '0;
                                state     <= IDLE;
                            end else begin
                                r_cnt     <= r_cnt + 1'b1;
                                rd_addr_m <= rd_addr_m + 1'b1;
                            end
                        end else begin
                            rd_addr_x <= rd_addr_x + 1'b1;
                            rd_addr_m <= rd_addr_m + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Row credits: rows started but not yet taken from the output port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding <= 2'd0;
        end else begin
            unique case ({row_start, out_hs})
                2'b10:   outstanding <= outstanding + 2'd1;
                2'b01:   outstanding <= outstanding - 2'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Tag pipeline aligning first/last markers with the accumulator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pv     <= '0;
            push_q <= 1'b0;
            for (int i = 0; i < PIPE; i++) begin
                pt[i] <= '0;
            end
        end else begin
            pv[0]       <= issue;
            pt[0].first <= (rd_addr_x == '0);
            pt[0].last  <= col_last;
            for (int i = 1; i < PIPE; i++) begin
                pv[i] <= pv[i-1];
                pt[i] <= pt[i-1];
            end
            push_q <= pv[PIPE-1] & pt[PIPE-1].last;
        end
    end

    matvec_outbuf #(
        .W (OUT_W)
    ) u_outbuf (
        .clk   (clk),
        .reset (reset),
        .push  (push_q),
        .din   (acc_in),
        .pop   (output_ready),
        .valid (output_valid),
        .dout  (output_data),
        .count (buf_cnt)
    );

    a_buf_overflow: assert property (
        @(posedge clk) disable iff (!reset)
        !(push_q && (buf_cnt == 2'd2) && !out_hs)
    );

endmodule

// File: tb/tb_matvec_seq_ctrl.sv
// Bench for matvec_seq_ctrl with a behavioural datapath and a golden
// matrix-vector model feeding an expected-result queue.
module tb_matvec_seq_ctrl;
    import matvec_pkg::*;

    typedef struct packed {
        logic [15:0] d;
        logic        nm;
        logic        last;
    } word_t;

    logic              clk;
    logic              reset;
    logic              input_valid;
    logic              input_ready;
    logic              new_matrix;
    logic              wr_en_m;
    logic              wr_en_x;
    logic [AW_M-1:0]   wr_addr;
    logic [AW_M-1:0]   rd_addr_m;
    logic [AW_X-1:0]   rd_addr_x;
    logic              mac_en;
    logic              mac_clr;
    logic [27:0]       acc_in;
    logic              output_valid;
    logic              output_ready;
    logic [27:0]       output_data;

    logic signed [15:0] din;
    logic signed [15:0] mm [64] = '{default: 16'sd0};
    logic signed [15:0] xm [8]  = '{default: 16'sd0};
    logic signed [31:0] pr1 = 32'sd0;
    logic signed [31:0] pr2 = 32'sd0;
    logic signed [27:0] acc = 28'sd0;

    int     n_chk;
    int     n_fail;
    int     n_extra;
    int     cyc;
    int     t_last;
    bit     lat_req;
    bit     lat_arm;
    int     gm [64];
    word_t  wq [$];
    longint eq [$];

    matvec_seq_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .new_matrix   (new_matrix),
        .wr_en_m      (wr_en_m),
        .wr_en_x      (wr_en_x),
        .wr_addr      (wr_addr),
        .rd_addr_m    (rd_addr_m),
        .rd_addr_x    (rd_addr_x),
        .mac_en       (mac_en),
        .mac_clr      (mac_clr),
        .acc_in       (acc_in),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: memories, two-stage product pipe, accumulator.
    always @(posedge clk) begin
        if (wr_en_m) mm[wr_addr] <= din;
        if (wr_en_x) xm[wr_addr[2:0]] <= din;
        pr1 <= mm[rd_addr_m] * xm[rd_addr_x];
        pr2 <= pr1;
        if (mac_en) acc <= mac_clr ? pr2[27:0] : acc + pr2[27:0];
    end
    assign acc_in = acc;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint wrap28(input longint v);
        return (v <<< 36) >>> 36;
    endfunction

    task automatic add_job(input bit nm, input int mv[64], input int xv[8]);
        word_t w;
        longint s;
        if (nm) for (int i = 0; i < 64; i++) gm[i] = mv[i];
        for (int r = 0; r < 8; r++) begin
            s = 0;
            for (int c = 0; c < 8; c++)
                s += longint'(gm[r*8+c]) * longint'(xv[c]);
            eq.push_back(wrap28(s));
        end
        if (nm) begin
            for (int i = 0; i < 64; i++) begin
                w.d    = 16'(mv[i]);
                w.nm   = (i == 0) ? 1'b1 : 1'($urandom_range(1));
                w.last = 1'b0;
                wq.push_back(w);
            end
        end
        for (int c = 0; c < 8; c++) begin
            w.d    = 16'(xv[c]);
            w.nm   = (!nm && c == 0) ? 1'b0 : 1'($urandom_range(1));
            w.last = (c == 7);
            wq.push_back(w);
        end
    endtask

    task automatic rand_job(output int mv[64], output int xv[8]);
        for (int i = 0; i < 64; i++) mv[i] = int'($urandom_range(1023)) - 512;
        for (int i = 0; i < 8; i++) xv[i] = int'($urandom_range(1023)) - 512;
    endtask

    task automatic tick(input int vp, input int rp);
        word_t w;
        @(negedge clk);
        w = (wq.size() != 0) ? wq[0] : '0;
        input_valid  = (wq.size() != 0) && (int'($urandom_range(99)) < vp);
        new_matrix   = input_valid ? w.nm : 1'($urandom_range(1));
        din          = w.d;
        output_ready = (int'($urandom_range(99)) < rp);
        #1;
        if (input_valid && input_ready) begin
            if (w.last && lat_req) begin
                t_last  = cyc;
                lat_arm = 1'b1;
                lat_req = 1'b0;
            end
            void'(wq.pop_front());
        end
        if (output_valid) begin
            chk("out_x", longint'($isunknown(output_data)), 0);
            if (lat_arm) begin
                chk("latency", longint'(cyc - t_last), 12);
                lat_arm = 1'b0;
            end
        end
        if (output_valid && output_ready) begin
            if (eq.size() == 0) n_extra++;
            else chk("out_data", longint'($signed(output_data)), eq.pop_front());
        end
    endtask

    task automatic drain(input int vp, input int rp, input int budget);
        int n = 0;
        while ((wq.size() != 0 || eq.size() != 0) && n < budget) begin
            tick(vp, rp);
            n++;
        end
        chk("drain_left", longint'(wq.size() + eq.size()), 0);
    endtask

    initial begin
        int mv[64];
        int xv[8];
        int n;
        n_chk = 0; n_fail = 0; n_extra = 0; cyc = 0;
        lat_req = 0; lat_arm = 0;
        foreach (gm[i]) gm[i] = 0;

        // reset with a word offered: nothing may be written
        reset = 1'b0; input_valid = 1'b1; new_matrix = 1'b1;
        din = 16'sd0; output_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rst_wr_en", longint'({wr_en_m, wr_en_x}), 0);
            chk("rst_in_rdy", longint'(input_ready), 0);
            chk("rst_out_vld", longint'(output_valid), 0);
            chk("rst_out_data", longint'(output_data), 0);
            chk("rst_mac_en", longint'(mac_en), 0);
        end
        @(negedge clk);
        reset = 1'b1; input_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_rdy", longint'(input_ready), 1);
        chk("post_rst_out_vld", longint'(output_valid), 0);

        // identity matrix, x = 1..8, with first-result latency
        for (int i = 0; i < 64; i++) mv[i] = (i / 8 == i % 8) ? 1 : 0;
        for (int i = 0; i < 8; i++) xv[i] = i + 1;
        lat_req = 1'b1;
        add_job(1'b1, mv, xv);
        drain(100, 100, 2000);
        chk("latency_seen", longint'(lat_req | lat_arm), 0);

        // full-scale operands, then a vector-only job reusing the matrix
        for (int i = 0; i < 64; i++) mv[i] = 8191;
        add_job(1'b1, mv, xv);
        for (int i = 0; i < 8; i++) xv[i] = -8192;
        add_job(1'b0, mv, xv);
        drain(100, 100, 2000);

        // output back-pressure during compute
        rand_job(mv, xv);
        add_job(1'b1, mv, xv);
        n = 0;
        while (wq.size() != 0 && n < 1000) begin
            tick(100, 100);
            n++;
        end
        repeat (50) tick(100, 0);
        chk("stall_rd_addr_m", longint'(rd_addr_m), 16);
        chk("stall_rd_addr_x", longint'(rd_addr_x), 0);
        chk("stall_mac_en", longint'(mac_en), 0);
        chk("stall_out_vld", longint'(output_valid), 1);
        chk("stall_in_rdy", longint'(input_ready), 0);
        chk("stall_head", longint'($signed(output_data)),
            (eq.size() != 0) ? eq[0] : 64'sd1 <<< 40);
        drain(100, 100, 2000);

        // random traffic on both ports
        for (int j = 0; j < 300; j++) begin
            rand_job(mv, xv);
            add_job(($urandom_range(99) < 30), mv, xv);
        end
        drain(50, 50, 90000);

        // reset during row 3 of compute
        rand_job(mv, xv);
        add_job(1'b1, mv, xv);
        n = 0;
        while (rd_addr_m < 6'd24 && n < 1000) begin
            tick(100, 100);
            n++;
        end
        chk("mid_reached_row3", longint'(rd_addr_m >= 6'd24), 1);
        @(negedge clk);
        reset = 1'b0; input_valid = 1'b0;
        #1;
        chk("mid_rst_out_vld", longint'(output_valid), 0);
        chk("mid_rst_mac_en", longint'(mac_en), 0);
        chk("mid_rst_in_rdy", longint'(input_ready), 0);
        wq.delete();
        eq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rand_job(mv, xv);
        add_job(1'b1, mv, xv);
        drain(100, 100, 2000);
        repeat (40) tick(100, 100);
        chk("spurious_outputs", longint'(n_extra), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
